// File: rtl/fc_stream_host.sv
// rtl/fc_stream_host.sv - host endpoint that streams an input vector into an fc layer and captures its outputs
module fc_stream_host #(
    parameter int M = 4,
    parameter int N = 8,
    parameter int T = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 ld_en_i,
    input  logic [$clog2(N)-1:0] ld_addr_i,
    input  logic [T-1:0]         ld_data_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [T-1:0]         tx_data_o,
    input  logic                 rx_valid_i,
    output logic                 rx_ready_o,
    input  logic [T-1:0]         rx_data_i,
    input  logic                 rx_stall_i,
    input  logic [$clog2(M)-1:0] rd_addr_i,
    output logic [T-1:0]         rd_data_o
);

    localparam int NW = $clog2(N);
    localparam int MW = $clog2(M);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [T-1:0]    xbuf_q [N];
    logic [T-1:0]    ybuf_q [M];
    logic [NW-1:0]   tx_idx_q;
    logic [MW-1:0]   rx_idx_q;
    logic [T-1:0]    rd_data_q;
    logic            tx_hs;
    logic            rx_hs;
    logic            tx_last;
    logic            rx_last;

    assign tx_hs   = tx_valid_o & tx_ready_i;
    assign rx_hs   = rx_valid_i & rx_ready_o;
    assign tx_last = (32'(tx_idx_q) == N - 1);
    assign rx_last = (32'(rx_idx_q) == M - 1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_SEND;
            S_SEND: if (tx_hs && tx_last) state_d = S_RECV;
            S_RECV: if (rx_hs && rx_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decode only the registered state; rx_stall is the one live input term.
    always_comb begin
        busy_o     = (state_q == S_SEND) || (state_q == S_RECV);
        done_o     = (state_q == S_DONE);
        tx_valid_o = (state_q == S_SEND);
        rx_ready_o = (state_q == S_RECV) && !rx_stall_i;
    end

    assign tx_data_o = xbuf_q[tx_idx_q];
    assign rd_data_o = rd_data_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < N; i++) xbuf_q[i] <= '0;
            for (int j = 0; j < M; j++) ybuf_q[j] <= '0;
            tx_idx_q  <= '0;
            rx_idx_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                if (ld_en_i && (32'(ld_addr_i) < N)) begin
                    xbuf_q[ld_addr_i] <= ld_data_i;
                end
                if (start_i) begin
                    tx_idx_q <= '0;
                    rx_idx_q <= '0;
                end
            end
            if (tx_hs) begin
                tx_idx_q <= tx_idx_q + NW'(1);
            end
            if (rx_hs) begin
                ybuf_q[rx_idx_q] <= rx_data_i;
                rx_idx_q         <= rx_idx_q + MW'(1);
            end
            // Reads see the pre-edge buffer, so a same-cycle capture returns the old word.
            rd_data_q <= (32'(rd_addr_i) < M) ? ybuf_q[rd_addr_i] : '0;
        end
    end

endmodule

// File: tb/tb_fc_stream_host.sv
// tb/tb_fc_stream_host.sv - directed/random bench for fc_stream_host with a behavioural layer model
module tb_fc_stream_host;
    localparam int M = 4;
    localparam int N = 8;
    localparam int T = 16;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          ld_en_i;
    logic [2:0]    ld_addr_i;
    logic [T-1:0]  ld_data_i;
    logic          start_i;
    logic          busy_o;
    logic          done_o;
    logic          tx_valid_o;
    logic          tx_ready_i;
    logic [T-1:0]  tx_data_o;
    logic          rx_valid_i;
    logic          rx_ready_o;
    logic [T-1:0]  rx_data_i;
    logic          rx_stall_i;
    logic [1:0]    rd_addr_i;
    logic [T-1:0]  rd_data_o;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [T-1:0] xm [N];
    logic [T-1:0] ym [M];
    logic [T-1:0] sent [$];
    int           w [M][N];
    int           fixed_v [M] = '{10, -20, 30, -40};
    bit           layer_fixed;

    fc_stream_host #(.M(M), .N(N), .T(T)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .ld_en_i(ld_en_i), .ld_addr_i(ld_addr_i),
        .ld_data_i(ld_data_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
        .rx_stall_i(rx_stall_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (done_o === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [T-1:0] layer_out(int j);
        int acc = 0;
        if (layer_fixed) return T'(fixed_v[j]);
        for (int i = 0; i < N; i++) acc += w[j][i] * int'(signed'(sent[i]));
        return (acc < 0) ? '0 : T'(acc);
    endfunction

    task automatic load_all();
        for (int i = 0; i < N; i++) begin
            ld_en_i = 1'b1; ld_addr_i = 3'(i); ld_data_i = xm[i];
            tick();
        end
        ld_en_i = 1'b0;
    endtask

    task automatic readback();
        for (int a = 0; a < M; a++) begin
            rd_addr_i = 2'(a);
            tick();
            chk($sformatf("rd_addr%0d", a), rd_data_o, ym[a]);
        end
    endtask

    task automatic rand_weights();
        for (int j = 0; j < M; j++)
            for (int i = 0; i < N; i++) w[j][i] = int'($urandom_range(200)) - 100;
    endtask

    // Runs one transaction from the start pulse; abort_after >= 0 returns inside RECV after that many results.
    task automatic do_run(input bit rnd_tx, input int stall_word, input bit ld_in_send,
                          input int abort_after, input int exp_cycles);
        int cyc;
        int nsent;
        int base;
        logic [T-1:0] y [M];
        logic [T-1:0] d;
        sent.delete();
        base = done_cnt;
        start_i = 1'b1;
        tick();
        start_i = 1'b0; ld_en_i = 1'b0;
        cyc = 1;
        chk("busy_cycle1", busy_o, 1);
        nsent = 0;
        while (nsent < N && cyc < 200) begin
            chk("tx_valid_send", tx_valid_o, 1);
            chk($sformatf("tx_data_word%0d", nsent), tx_data_o, xm[nsent]);
            chk("rx_ready_in_send", rx_ready_o, 0);
            d = tx_data_o;
            tx_ready_i = rnd_tx ? 1'($urandom % 2) : 1'b1;
            rx_valid_i = 1'b1; rx_data_i = 16'hdead;
            if (ld_in_send && nsent == 2) begin
                ld_en_i = 1'b1; ld_addr_i = 3'd0; ld_data_i = 16'd99;
            end else begin
                ld_en_i = 1'b0;
            end
            tick();
            cyc++;
            if (tx_ready_i) begin
                sent.push_back(d);
                nsent++;
            end
        end
        tx_ready_i = 1'b0; ld_en_i = 1'b0; rx_valid_i = 1'b0;
        chk("tx_handshake_count", nsent, N);
        chk("tx_valid_recv", tx_valid_o, 0);
        if (nsent != N) return;
        for (int j = 0; j < M; j++) y[j] = layer_out(j);
        for (int j = 0; j < M; j++) begin
            if (abort_after == j) return;
            rx_valid_i = 1'b1; rx_data_i = y[j];
            if (j == stall_word) begin
                rx_stall_i = 1'b1; rd_addr_i = 2'(j);
                for (int s = 0; s < 5; s++) begin
                    #1;
                    chk("rx_ready_stalled", rx_ready_o, 0);
                    tick();
                    cyc++;
                    chk("ybuf_during_stall", rd_data_o, ym[j]);
                end
                rx_stall_i = 1'b0;
            end
            #1;
            chk("rx_ready_recv", rx_ready_o, 1);
            chk("no_early_done", done_o, 0);
            tick();
            cyc++;
            ym[j] = y[j];
        end
        rx_valid_i = 1'b0;
        chk("done_high", done_o, 1);
        chk("busy_in_done", busy_o, 0);
        if (exp_cycles > 0) chk("run_length", cyc, exp_cycles);
        tick();
        chk("done_one_cycle", done_o, 0);
        chk("done_pulse_count", done_cnt - base, 1);
    endtask

    initial begin
        int base;
        reset_i = 1'b1; ld_en_i = 1'b0; ld_addr_i = '0; ld_data_i = '0; start_i = 1'b0;
        tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0; rx_stall_i = 1'b0; rd_addr_i = '0;
        for (int j = 0; j < M; j++) ym[j] = '0;
        tick(); tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_tx_valid", tx_valid_o, 0);
        chk("rst_tx_data", tx_data_o, 0);
        chk("rst_rx_ready", rx_ready_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        reset_i = 1'b0;
        tick();

        for (int i = 0; i < N; i++) xm[i] = T'(i + 1);
        load_all();
        layer_fixed = 1'b1;
        do_run(1'b0, -1, 1'b0, -1, N + M + 1);
        readback();

        layer_fixed = 1'b0;
        rand_weights();
        for (int i = 0; i < N; i++) xm[i] = T'($urandom);
        load_all();
        do_run(1'b1, -1, 1'b0, -1, 0);
        readback();

        rand_weights();
        do_run(1'b0, 2, 1'b0, -1, N + M + 1 + 5);
        readback();

        ld_en_i = 1'b1; ld_addr_i = 3'd3; ld_data_i = 16'h7fff;
        xm[3] = 16'h7fff;
        do_run(1'b0, -1, 1'b1, -1, N + M + 1);
        chk("sent_word3_7fff", sent[3], 16'h7fff);
        readback();
        do_run(1'b0, -1, 1'b0, -1, N + M + 1);
        chk("ld_in_send_ignored", sent[0], xm[0]);

        base = done_cnt;
        do_run(1'b0, -1, 1'b0, 2, 0);
        rx_valid_i = 1'b0;
        reset_i = 1'b1;
        tick();
        chk("abort_busy", busy_o, 0);
        chk("abort_tx_valid", tx_valid_o, 0);
        chk("abort_rx_ready", rx_ready_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_tx_data", tx_data_o, 0);
        chk("abort_rd_data", rd_data_o, 0);
        reset_i = 1'b0;
        for (int i = 0; i < N; i++) xm[i] = '0;
        for (int j = 0; j < M; j++) ym[j] = '0;
        readback();
        chk("abort_no_done", done_cnt - base, 0);

        rand_weights();
        xm[0] = 16'd1;
        load_all();
        do_run(1'b0, -1, 1'b0, -1, N + M + 1);
        for (int j = 0; j < M; j++) chk($sformatf("relu_col0_%0d", j), ym[j], (w[j][0] < 0) ? 0 : w[j][0]);
        readback();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
